// File: rtl/instr_encode_loader_pkg.sv
// instr_encode_loader_pkg: instruction formats, loader states and LEGv8 field layout
package instr_encode_loader_pkg;
  localparam int INSTR_LEN = 32;
  localparam int OPW_R = 11, OPW_D = 11, OPW_I = 10, OPW_B = 6, OPW_CB = 8;
  localparam int D_IMM_W = 9, I_IMM_W = 12, CB_IMM_W = 19;
  typedef enum logic [2:0] {FMT_R, FMT_D, FMT_I, FMT_B, FMT_CB} fmt_e;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ERR, S_FULL} state_e;
  function automatic int op_width(input logic [2:0] f);
    return f == FMT_I ? OPW_I : f == FMT_B ? OPW_B : f == FMT_CB ? OPW_CB : f == FMT_D ? OPW_D : OPW_R;
  endfunction
endpackage

// File: rtl/instr_encode_loader_if.sv
// instr_encode_loader_if: field-bundle valid/ready channel into the loader
interface instr_encode_loader_if;
  logic in_valid;
  logic in_ready;
  logic [2:0] in_fmt;
  logic [10:0] in_opcode;
  logic [4:0] in_rm;
  logic [4:0] in_rn;
  logic [4:0] in_rd;
  logic [5:0] in_shamt;
  logic [25:0] in_imm;
  modport master (output in_valid, in_fmt, in_opcode, in_rm, in_rn, in_rd, in_shamt, in_imm, input in_ready);
  modport slave (input in_valid, in_fmt, in_opcode, in_rm, in_rn, in_rd, in_shamt, in_imm, output in_ready);
endinterface

// File: rtl/instr_encode_loader_pack.sv
// instr_pack: packs LEGv8 fields into a machine word and flags illegal bundles
module instr_pack
  import instr_encode_loader_pkg::*;
(
  input  logic [2:0]           fmt,
  input  logic [10:0]          op,
  input  logic [4:0]           rm,
  input  logic [4:0]           rn,
  input  logic [4:0]           rd,
  input  logic [5:0]           shamt,
  input  logic [25:0]          imm,
  output logic [INSTR_LEN-1:0] word,
  output logic                 illegal
);
  logic [INSTR_LEN-1:0] r_w, d_w, i_w, b_w, cb_w;
  always_comb begin
    r_w = {op, rm, shamt, rn, rd};
    d_w = {op, imm[D_IMM_W-1:0], 2'b00, rn, rd};
    i_w = {op[OPW_I-1:0], imm[I_IMM_W-1:0], rn, rd};
    b_w = {op[OPW_B-1:0], imm};
    cb_w = {op[OPW_CB-1:0], imm[CB_IMM_W-1:0], rd};
    word = fmt == FMT_R ? r_w : fmt == FMT_D ? d_w : fmt == FMT_I ? i_w :
           fmt == FMT_B ? b_w : fmt == FMT_CB ? cb_w : '0;
    illegal = fmt > 3'd4 || (op >> op_width(fmt)) != '0 ||
              (fmt == FMT_D && imm[25:D_IMM_W] != '0) ||
              (fmt == FMT_I && imm[25:I_IMM_W] != '0) ||
              (fmt == FMT_CB && imm[25:CB_IMM_W-1] != '0 && imm[25:CB_IMM_W-1] != '1);
  end
endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs field bundles and writes them sequentially into instruction memory
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int              ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              DEPTH     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  instr_encode_loader_if.slave       bus,
  output logic                       imem_we,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [INSTR_LEN-1:0]       imem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       err
);
  localparam int CW = $clog2(DEPTH+1);
  state_e state;
  logic we_r, illegal, last;
  logic [INSTR_LEN-1:0] word;
  instr_pack u_pack (
    .fmt(bus.in_fmt), .op(bus.in_opcode), .rm(bus.in_rm), .rn(bus.in_rn), .rd(bus.in_rd),
    .shamt(bus.in_shamt), .imm(bus.in_imm), .word(word), .illegal(illegal)
  );
  assign imem_we = we_r && !flush;
  assign last = count == CW'(DEPTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bus.in_ready <= 1'b1;
      we_r <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_wdata <= '0;
      count <= '0;
      full <= 1'b0;
      err <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      bus.in_ready <= 1'b1;
      we_r <= 1'b0;
      imem_addr <= BASE_ADDR;
      count <= '0;
      full <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid && bus.in_ready) begin
          imem_wdata <= word;
          bus.in_ready <= 1'b0;
          we_r <= !illegal;
          err <= illegal;
          state <= illegal ? S_ERR : S_WRITE;
        end
        S_WRITE: begin
          we_r <= 1'b0;
          count <= count + 1'b1;
          imem_addr <= imem_addr + ADDR_W'(4);
          full <= last;
          bus.in_ready <= !last;
          state <= last ? S_FULL : S_IDLE;
        end
        S_ERR: begin
          err <= 1'b0;
          bus.in_ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_FULL;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed vector table plus hand sequences for full, flush and reset
module tb_instr_encode_loader;
  typedef struct packed {
    logic        fl;
    logic [2:0]  fmt;
    logic [10:0] op;
    logic [4:0]  rm, rn, rd;
    logic [5:0]  sh;
    logic [25:0] imm;
    logic        e;
    logic [31:0] w;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic imem_we, full, err;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0] count;
  int n_chk = 0, n_bad = 0, exp_cnt = 0;
  vec_t tv[12];
  instr_encode_loader_if bus();
  instr_encode_loader #(.ADDR_W(64), .BASE_ADDR(64'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic vec_t mk(input logic fl, input logic [2:0] fmt, input logic [10:0] op,
                              input logic [4:0] rm, rn, rd, input logic [5:0] sh,
                              input logic [25:0] imm, input logic e, input logic [31:0] w);
    vec_t v;
    v.fl = fl; v.fmt = fmt; v.op = op; v.rm = rm; v.rn = rn; v.rd = rd;
    v.sh = sh; v.imm = imm; v.e = e; v.w = w;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.in_fmt = v.fmt; bus.in_opcode = v.op; bus.in_rm = v.rm; bus.in_rn = v.rn;
    bus.in_rd = v.rd; bus.in_shamt = v.sh; bus.in_imm = v.imm;
  endtask
  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    exp_cnt = 0;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " ready"}, bus.in_ready, 1);
    chk({nm, " we"}, imem_we, 0);
    chk({nm, " addr"}, imem_addr, 0);
    chk({nm, " wdata"}, imem_wdata, 0);
    chk({nm, " count"}, count, 0);
    chk({nm, " full"}, full, 0);
    chk({nm, " err"}, err, 0);
  endtask
  task automatic send(input vec_t v, input string nm);
    int n = 0;
    if (v.fl) do_flush();
    @(negedge clk);
    drive(v);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, bus.in_ready, 1);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({nm, " we"}, imem_we, !v.e);
    chk({nm, " err"}, err, v.e);
    if (!v.e) begin
      chk({nm, " addr"}, imem_addr, 64'(exp_cnt * 4));
      chk({nm, " wdata"}, imem_wdata, v.w);
      exp_cnt++;
    end
    @(negedge clk);
    chk({nm, " count"}, count, exp_cnt);
  endtask
  initial begin
    logic saw;
    tv[0]  = mk(0, 3'd1, 11'd1986, 5'd0, 5'd22, 5'd9,  6'd0, 26'd240, 0, 32'hF84F02C9);
    tv[1]  = mk(0, 3'd0, 11'd1112, 5'd9, 5'd21, 5'd10, 6'd0, 26'd0,   0, 32'h8B0902AA);
    tv[2]  = mk(0, 3'd1, 11'd1984, 5'd0, 5'd23, 5'd10, 6'd0, 26'd64,  0, 32'hF80402EA);
    tv[3]  = mk(1, 3'd2, 11'h244,  5'd0, 5'd2,  5'd1,  6'd0, 26'd5,   0, 32'h91001441);
    tv[4]  = mk(0, 3'd3, 11'd5,    5'd7, 5'd7,  5'd7,  6'd9, 26'd3,   0, 32'h14000003);
    tv[5]  = mk(0, 3'd4, 11'hB4,   5'd0, 5'd0,  5'd3,  6'd0, 26'h3FFFFFE, 0, 32'hB4FFFFC3);
    tv[6]  = mk(1, 3'd6, 11'd0,    5'd0, 5'd0,  5'd0,  6'd0, 26'd0,   1, 32'h0);
    tv[7]  = mk(0, 3'd1, 11'd1986, 5'd0, 5'd22, 5'd9,  6'd0, 26'd512, 1, 32'h0);
    tv[8]  = mk(0, 3'd4, 11'hB4,   5'd0, 5'd0,  5'd3,  6'd0, 26'h0040000, 1, 32'h0);
    tv[9]  = mk(0, 3'd2, 11'h644,  5'd0, 5'd2,  5'd1,  6'd0, 26'd5,   1, 32'h0);
    tv[10] = mk(0, 3'd3, 11'h45,   5'd0, 5'd0,  5'd0,  6'd0, 26'd3,   1, 32'h0);
    tv[11] = mk(0, 3'd0, 11'h458,  5'd1, 5'd4,  5'd5,  6'd3, 26'h3FFFFFF, 0, 32'h8B010C85);
    bus.in_valid = 1'b0;
    drive(tv[0]);
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) send(tv[i], $sformatf("v%0d", i));
    do_flush();
    send(tv[0], "full0");
    send(tv[1], "full1");
    send(tv[2], "full2");
    send(tv[4], "full3");
    chk("full flag", full, 1);
    chk("full ready", bus.in_ready, 0);
    chk("full count", count, 4);
    saw = 1'b0;
    drive(tv[3]);
    bus.in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      saw |= imem_we;
    end
    bus.in_valid = 1'b0;
    chk("full no write", saw, 0);
    chk("full count held", count, 4);
    do_flush();
    chk("flush count", count, 0);
    chk("flush ready", bus.in_ready, 1);
    chk("flush full", full, 0);
    send(tv[1], "after flush");
    @(negedge clk);
    drive(tv[2]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush-in-write we", imem_we, 0);
    @(negedge clk);
    flush = 1'b0;
    exp_cnt = 0;
    chk("flush-in-write count", count, 0);
    chk("flush-in-write ready", bus.in_ready, 1);
    chk("flush-in-write addr", imem_addr, 0);
    send(tv[0], "reset pre");
    @(negedge clk);
    drive(tv[1]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("reset-in-write we", imem_we, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk_reset("reset-in-write");
    send(tv[1], "rst+flush pre");
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    exp_cnt = 0;
    chk_reset("rst+flush");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the instruction field parser. Accepts LEGv8 instruction fields plus a format tag over a valid/ready handshake and packs them into a 32-bit machine word.
- Writes each packed word sequentially into the instruction memory write port, starting at a base byte address.
- Used by the testbench/boot infrastructure to load programs without hand-assembled hex.

Parameters:
- ADDR_W, 64, width of instruction-memory byte address.
- BASE_ADDR, 0, byte address of the first word written.
- DEPTH, 64, maximum number of words loaded before FULL. Must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous restart: clear count, return to IDLE; lower priority than rst
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle
- in_fmt  in  3  0=R, 1=D, 2=I, 3=B, 4=CB; 5–7 illegal
- in_opcode  in  11  opcode, right-justified (R/D 11b, I 10b, CB 8b, B 6b)
- in_rm  in  5  R-type Rm
- in_rn  in  5  Rn (R/D/I)
- in_rd  in  5  Rd / Rt (R/D/I/CB)
- in_shamt  in  6  R-type shamt
- in_imm  in  26  D address, I immediate, B/CB branch offset (two's complement)
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  byte address = BASE_ADDR + 4*count
- imem_wdata  out  `INSTR_LEN  packed instruction
- count  out  $clog2(DEPTH+1)  words written
- full  out  1  count == DEPTH
- err  out  1  one-cycle pulse: bundle rejected

Behaviour:
- Reset values: in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0, state=IDLE.
- Handshake: transfer when in_valid && in_ready. in_ready=1 only in IDLE and only when not full.
- FSM:
  - IDLE: on transfer, register the packed word. Legal bundle -> WRITE. Illegal bundle -> ERR.
  - WRITE: imem_we=1 for exactly one cycle, using the registered addr/data. Then count+=1. Next state is FULL if the new count equals DEPTH, else IDLE.
  - ERR: err=1 for one cycle, no write, count unchanged -> IDLE.
  - FULL: in_ready=0, full=1; stays until rst or flush.
- Latency: one word per 2 cycles. imem_we is asserted the cycle after the transfer.
- Packing:
  - R: opcode[31:21], rm[20:16], shamt[15:10], rn[9:5], rd[4:0].
  - D: opcode[31:21], imm[8:0]→[20:12], op2[11:10]=00, rn, rt.
  - I: opcode[9:0]→[31:22], imm[11:0]→[21:10], rn, rd.
  - B: opcode[5:0]→[31:26], imm[25:0].
  - CB: opcode[7:0]→[31:24], imm[18:0]→[23:5], rt.
- Illegal bundle conditions:
  - in_fmt > 4.
  - Nonzero opcode bits above the format's opcode width.
  - R/D/I: imm bits above the field width are nonzero (D: imm[25:9]; I: imm[25:12]; R ignores imm).
  - CB: imm[25:19] is not the sign extension of imm[18].
  - Fields unused by a format are ignored.
- imem_addr wraps modulo 2^ADDR_W with no error.
- flush takes effect in any state, including mid-WRITE. The pending write is cancelled: imem_we=0 that cycle, count=0, state -> IDLE.
- rst and flush both asserted: rst behaviour applies.
- in_valid while in_ready=0: ignored. The source must hold the bundle.

Decomposition:
- Shared package holds:
  - fmt enum (FMT_R, FMT_D, FMT_I, FMT_B, FMT_CB).
  - FSM state enum.
  - Per-format opcode widths and field bit-position constants, shared with instr_parse.
- One combinational sub-module, instr_pack: fields + fmt -> word + illegal flag. The top-level holds the FSM, counter and address register.

Test Plan:
- R, D, I packing: the three bundles below -> F84F02C9, 8B0902AA, F80402EA written at addresses 0, 4, 8; count=3.
  - fmt=D, op=1986, imm=240, rn=22, rd=9
  - fmt=R, op=1112, rm=9, shamt=0, rn=21, rd=10
  - fmt=D, op=1984, imm=64, rn=23, rd=10
- I, B, CB packing:
  - fmt=I, op=0x244, imm=5, rn=2, rd=1 -> 91001441.
  - fmt=B, op=5, imm=3 -> 14000003.
  - fmt=CB, op=0xB4, imm=-2 (26-bit), rd=3 -> B4FFFFC3.
- Errors:
  - fmt=6 -> err pulse, no imem_we, count unchanged.
  - fmt=D with imm=512 -> err.
  - A following legal bundle is written at the unchanged address.
- Full: DEPTH=4; stream 5 legal bundles -> 4 writes (addr 0..12), full=1, in_ready=0, 5th never accepted. flush -> count=0, in_ready=1, next write at addr 0.
- Flush in WRITE: assert flush in the cycle imem_we would be high -> imem_we=0, count=0, state IDLE.
- Reset mid-op: rst in WRITE -> all outputs at reset values next cycle. Then rst together with flush -> reset values.
